// File: rtl/decoder_seq_if.sv
// Control/strobe bundle between a sequencer client and decoder_seq.
// The client drives the controls and observes the strobes, index and status pulses.
interface decoder_seq_if #(
   parameter int unsigned SEL_SIZE = 3,
   parameter int unsigned OUT_SIZE = 2 ** SEL_SIZE
);
   logic                clr;
   logic                load;
   logic [SEL_SIZE-1:0] sel;
   logic                step;
   logic                dir;
   logic                enable;
   logic [OUT_SIZE-1:0] y;
   logic [SEL_SIZE-1:0] idx;
   logic                term_c;
   logic                done;
   logic                err;

   modport master (
      output clr, load, sel, step, dir, enable,
      input  y, idx, term_c, done, err
   );

   modport slave (
      input  clr, load, sel, step, dir, enable,
      output y, idx, term_c, done, err
   );
endinterface

// File: rtl/decoder_seq.sv
// Registered one-hot/one-cold strobe sequencer with load, up/down step and wrap-or-stop
// at a terminal index; strobes reflect the index/state being entered on each edge.
module decoder_seq #(
   parameter int unsigned SEL_SIZE = 3,
   parameter int unsigned OUT_SIZE = 2 ** SEL_SIZE,
   parameter bit          ONE_COLD = 1'b0,
   parameter int unsigned LAST     = OUT_SIZE - 1,
   parameter bit          WRAP     = 1'b1
) (
   input  logic   clk,
   input  logic   rst_n,
   decoder_seq_if.slave bus
);
   localparam logic [SEL_SIZE-1:0] LAST_IDX = SEL_SIZE'(LAST);
   localparam logic [OUT_SIZE-1:0] IDLE_PAT = {OUT_SIZE{ONE_COLD}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state, state_nx;
   logic [SEL_SIZE-1:0] idx_q, idx_nx;
   logic [OUT_SIZE-1:0] y_q, y_nx, onehot;
   logic                done_q, done_nx;
   logic                err_q, err_nx;

   // Next index/state: clear beats load beats step.
   always_comb begin
      state_nx = state;
      idx_nx   = idx_q;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (bus.clr) begin
         state_nx = S_IDLE;
         idx_nx   = '0;
      end else if (bus.load) begin
         state_nx = S_RUN;
         if (bus.sel > LAST_IDX) begin
            idx_nx = LAST_IDX;
            err_nx = 1'b1;
         end else begin
            idx_nx = bus.sel;
         end
      end else if (bus.step && (state == S_RUN)) begin
         if (!bus.dir) begin
            if (idx_q != LAST_IDX) begin
               idx_nx = idx_q + SEL_SIZE'(1);
            end else if (WRAP) begin
               idx_nx = '0;
            end else begin
               state_nx = S_DONE;
               done_nx  = 1'b1;
            end
         end else begin
            if (idx_q != '0) begin
               idx_nx = idx_q - SEL_SIZE'(1);
            end else if (WRAP) begin
               idx_nx = LAST_IDX;
            end else begin
               state_nx = S_DONE;
               done_nx  = 1'b1;
            end
         end
      end
   end

   // Strobe decode from the values being entered, so strobes change with the index.
   always_comb begin
      onehot = OUT_SIZE'(1) << idx_nx;
      y_nx   = IDLE_PAT;
      if ((state_nx == S_RUN) && bus.enable) begin
         y_nx = ONE_COLD ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx_q  <= '0;
         y_q    <= IDLE_PAT;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         idx_q  <= idx_nx;
         y_q    <= y_nx;
         done_q <= done_nx;
         err_q  <= err_nx;
      end
   end

   assign bus.y      = y_q;
   assign bus.idx    = idx_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.term_c = bus.dir ? (idx_q == '0) : (idx_q == LAST_IDX);
endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: three configurations (wrap up to 7, stop at 5, one-cold)
// exercised by scenario tasks with hand-computed expectations.
module tb_decoder_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   decoder_seq_if #(.SEL_SIZE(3), .OUT_SIZE(8)) a_if ();
   decoder_seq_if #(.SEL_SIZE(3), .OUT_SIZE(8)) b_if ();
   decoder_seq_if #(.SEL_SIZE(3), .OUT_SIZE(8)) c_if ();

   decoder_seq #(.SEL_SIZE(3), .OUT_SIZE(8), .ONE_COLD(1'b0), .LAST(7), .WRAP(1'b1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   decoder_seq #(.SEL_SIZE(3), .OUT_SIZE(8), .ONE_COLD(1'b0), .LAST(5), .WRAP(1'b0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
   decoder_seq #(.SEL_SIZE(3), .OUT_SIZE(8), .ONE_COLD(1'b1), .LAST(7), .WRAP(1'b1))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_if.clr = 0; a_if.load = 0; a_if.sel = 0; a_if.step = 0; a_if.dir = 0; a_if.enable = 1;
      b_if.clr = 0; b_if.load = 0; b_if.sel = 0; b_if.step = 0; b_if.dir = 0; b_if.enable = 1;
      c_if.clr = 0; c_if.load = 0; c_if.sel = 0; c_if.step = 0; c_if.dir = 0; c_if.enable = 1;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
      vectors++;
      if (a_if.y !== 8'h00 || a_if.idx !== 3'd0 || a_if.done !== 1'b0 || a_if.err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_a_idle: y=%h idx=%0d done=%b err=%b, want y=00 idx=0 done=0 err=0",
                  a_if.y, a_if.idx, a_if.done, a_if.err);
      end
      vectors++;
      if (c_if.y !== 8'hFF) begin
         miscompares++;
         $display("FAIL reset_c_idle: y=%h want FF", c_if.y);
      end
      // Bring a to idx 5 mid-run, then pull reset between edges.
      a_if.load = 1; a_if.sel = 3'd5; c_if.load = 1; c_if.sel = 3'd2;
      tick();
      a_if.load = 0; c_if.load = 0;
      vectors++;
      if (a_if.idx !== 3'd5 || a_if.y !== 8'h20 || c_if.y !== 8'hFB) begin
         miscompares++;
         $display("FAIL pre_reset_run: a.idx=%0d a.y=%h c.y=%h, want 5 20 FB", a_if.idx, a_if.y, c_if.y);
      end
      #2;
      rst_n = 0;
      #1;
      vectors++;
      if (a_if.y !== 8'h00 || a_if.idx !== 3'd0 || a_if.done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_a: y=%h idx=%0d done=%b, want 00 0 0", a_if.y, a_if.idx, a_if.done);
      end
      vectors++;
      if (c_if.y !== 8'hFF || c_if.idx !== 3'd0) begin
         miscompares++;
         $display("FAIL async_reset_c: y=%h idx=%0d, want FF 0", c_if.y, c_if.idx);
      end
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_up_scan();
      logic [7:0] y_tab [9]   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      logic [2:0] idx_tab [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      logic [0:0] trm_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      a_if.dir = 0; a_if.load = 1; a_if.sel = 3'd0;
      tick();
      a_if.load = 0;
      vectors++;
      if (a_if.y !== 8'h01 || a_if.idx !== 3'd0 || a_if.term_c !== 1'b0) begin
         miscompares++;
         $display("FAIL up_load0: y=%h idx=%0d term=%b, want 01 0 0", a_if.y, a_if.idx, a_if.term_c);
      end
      a_if.step = 1;
      for (int i = 0; i < 9; i++) begin
         tick();
         vectors++;
         if (a_if.y !== y_tab[i] || a_if.idx !== idx_tab[i] || a_if.term_c !== trm_tab[i][0]
             || a_if.done !== 1'b0) begin
            miscompares++;
            $display("FAIL up_step%0d: y=%h idx=%0d term=%b done=%b, want %h %0d %b 0",
                     i, a_if.y, a_if.idx, a_if.term_c, a_if.done, y_tab[i], idx_tab[i], trm_tab[i][0]);
         end
      end
      a_if.step = 0;
   endtask

   task automatic test_down_stop();
      logic [2:0] idx_tab [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
      logic [7:0] y_tab [4]   = '{8'h02, 8'h01, 8'h00, 8'h00};
      logic [0:0] dn_tab [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      b_if.dir = 0; b_if.load = 1; b_if.sel = 3'd2;
      tick();
      b_if.load = 0;
      vectors++;
      if (b_if.idx !== 3'd2 || b_if.y !== 8'h04) begin
         miscompares++;
         $display("FAIL down_load2: idx=%0d y=%h, want 2 04", b_if.idx, b_if.y);
      end
      b_if.dir = 1; b_if.step = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (b_if.idx !== idx_tab[i] || b_if.y !== y_tab[i] || b_if.done !== dn_tab[i][0]) begin
            miscompares++;
            $display("FAIL down_step%0d: idx=%0d y=%h done=%b, want %0d %h %b",
                     i, b_if.idx, b_if.y, b_if.done, idx_tab[i], y_tab[i], dn_tab[i][0]);
         end
      end
      vectors++;
      if (b_if.term_c !== 1'b1) begin
         miscompares++;
         $display("FAIL down_term_at0: term=%b want 1", b_if.term_c);
      end
      b_if.step = 0; b_if.dir = 0;
   endtask

   task automatic test_clamp();
      b_if.load = 1; b_if.sel = 3'd7;
      tick();
      b_if.load = 0;
      vectors++;
      if (b_if.idx !== 3'd5 || b_if.err !== 1'b1 || b_if.y !== 8'h20 || b_if.term_c !== 1'b1) begin
         miscompares++;
         $display("FAIL clamp_load7: idx=%0d err=%b y=%h term=%b, want 5 1 20 1",
                  b_if.idx, b_if.err, b_if.y, b_if.term_c);
      end
      tick();
      vectors++;
      if (b_if.err !== 1'b0 || b_if.y !== 8'h20 || b_if.idx !== 3'd5) begin
         miscompares++;
         $display("FAIL clamp_hold: err=%b y=%h idx=%0d, want 0 20 5", b_if.err, b_if.y, b_if.idx);
      end
      b_if.step = 1;
      tick();
      b_if.step = 0;
      vectors++;
      if (b_if.done !== 1'b1 || b_if.idx !== 3'd5 || b_if.y !== 8'h00) begin
         miscompares++;
         $display("FAIL up_stop_at5: done=%b idx=%0d y=%h, want 1 5 00", b_if.done, b_if.idx, b_if.y);
      end
      tick();
      vectors++;
      if (b_if.done !== 1'b0 || b_if.idx !== 3'd5) begin
         miscompares++;
         $display("FAIL done_pulse_end: done=%b idx=%0d, want 0 5", b_if.done, b_if.idx);
      end
   endtask

   task automatic test_priority();
      a_if.clr = 1; a_if.load = 1; a_if.step = 1; a_if.sel = 3'd6;
      tick();
      vectors++;
      if (a_if.idx !== 3'd0 || a_if.y !== 8'h00 || a_if.err !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_clr: idx=%0d y=%h err=%b, want 0 00 0", a_if.idx, a_if.y, a_if.err);
      end
      a_if.clr = 0; a_if.load = 0;
      tick();
      vectors++;
      if (a_if.idx !== 3'd0 || a_if.y !== 8'h00) begin
         miscompares++;
         $display("FAIL step_in_idle: idx=%0d y=%h, want 0 00", a_if.idx, a_if.y);
      end
      a_if.load = 1; a_if.sel = 3'd4;
      tick();
      a_if.load = 0;
      vectors++;
      if (a_if.idx !== 3'd4 || a_if.y !== 8'h10) begin
         miscompares++;
         $display("FAIL prio_load_over_step: idx=%0d y=%h, want 4 10", a_if.idx, a_if.y);
      end
      tick();
      a_if.step = 0;
      vectors++;
      if (a_if.idx !== 3'd5 || a_if.y !== 8'h20) begin
         miscompares++;
         $display("FAIL step_after_load: idx=%0d y=%h, want 5 20", a_if.idx, a_if.y);
      end
   endtask

   task automatic test_one_cold();
      c_if.enable = 1; c_if.load = 1; c_if.sel = 3'd3;
      tick();
      c_if.load = 0; c_if.enable = 0;
      vectors++;
      if (c_if.y !== 8'hF7 || c_if.idx !== 3'd3) begin
         miscompares++;
         $display("FAIL cold_load3: y=%h idx=%0d, want F7 3", c_if.y, c_if.idx);
      end
      tick();
      c_if.enable = 1;
      vectors++;
      if (c_if.y !== 8'hFF || c_if.idx !== 3'd3) begin
         miscompares++;
         $display("FAIL cold_gate_off: y=%h idx=%0d, want FF 3", c_if.y, c_if.idx);
      end
      tick();
      vectors++;
      if (c_if.y !== 8'hF7) begin
         miscompares++;
         $display("FAIL cold_gate_on: y=%h want F7", c_if.y);
      end
   endtask

   initial begin
      test_reset();
      test_up_scan();
      test_down_stop();
      test_clamp();
      test_priority();
      test_one_cold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
